// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and sizing helper for the key debouncer
package key_pkg;

  // Per-channel debounce states; the WAIT states count stable samples toward a change
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b11,
    ST_RELEASE_WAIT = 2'b10
  } key_state_e;

  // Counter only has to reach cycles-1, so ceil(log2(cycles)) bits suffice (at least 1)
  function automatic int cnt_width(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - single key: synchroniser, stable-count FSM, level and pulses
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = '0;
  // Pin level while the key is not pressed; the synchroniser resets to it so
  // leaving reset never looks like an edge
  localparam logic           IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic          sync1;
  logic          sync2;
  logic          key_s;

  key_state_e    state;
  key_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_nxt;
  logic          press_nxt;
  logic          release_nxt;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Normalise so that 1 always means pressed from here on
  assign key_s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RELEASED;
      cnt         <= CNT_ZERO;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

  // Next-state: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // samples disagree with the current level; any agreeing sample restarts it.
  // The terminal compare leaves the WAIT state before the counter can wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      ST_RELEASED: begin
        if (key_s) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = CNT_ZERO;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_s) begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = CNT_ZERO;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!key_s) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = CNT_ZERO;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_s) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_RELEASED;
          cnt_nxt     = CNT_ZERO;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_RELEASED;
        cnt_nxt   = CNT_ZERO;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - NUM_KEYS independent debounced key channels
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // One fully independent channel per key; simultaneous events land in the same cycle
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed and random bench with stable-run reference model
module tb_key_debounce;

  localparam int NK = 2;
  localparam int DC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = 2'b11;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int checks = 0;
  int errors = 0;

  // Reference: pressed samples delayed two edges, then a run of disagreeing
  // samples of length DC flips the level
  bit            m_d1 [NK];
  bit            m_d2 [NK];
  bit            m_lvl[NK];
  int            m_run[NK];
  logic [NK-1:0] exp_level;
  logic [NK-1:0] exp_press;
  logic [NK-1:0] exp_release;

  key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #10 clk = ~clk;

  task automatic check_vec(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_d1[k]  = 1'b0;
      m_d2[k]  = 1'b0;
      m_lvl[k] = 1'b0;
      m_run[k] = 0;
    end
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
  endtask

  // One clock: advance model with the pin value this edge samples, then compare
  task automatic step();
    logic [NK-1:0] raw_s;
    logic          rst_s;
    bit            ks;
    raw_s = key_raw;
    rst_s = rst;
    @(posedge clk);
    #1;
    if (rst_s) begin
      model_reset();
    end else begin
      exp_press   = '0;
      exp_release = '0;
      for (int k = 0; k < NK; k++) begin
        ks      = m_d2[k];
        m_d2[k] = m_d1[k];
        m_d1[k] = ~raw_s[k];
        if (ks != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DC) begin
            m_lvl[k] = ks;
            m_run[k] = 0;
            if (ks) exp_press[k] = 1'b1;
            else    exp_release[k] = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
        exp_level[k] = m_lvl[k];
      end
    end
    check_vec("level", key_level, exp_level);
    check_vec("press", key_press, exp_press);
    check_vec("release", key_release, exp_release);
  endtask

  // Steps until the selected pulse vector is nonzero; returns edges taken (limit if none)
  task automatic wait_pulse(input bit want_release, input int limit, output int n, output logic [NK-1:0] seen);
    n    = limit;
    seen = '0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((want_release ? key_release : key_press) != '0) begin
        n    = i;
        seen = want_release ? key_release : key_press;
        break;
      end
    end
  endtask

  initial begin
    int            n;
    logic [NK-1:0] seen;
    int            hold[NK];
    int            pulses;

    model_reset();
    #1;
    check_vec("reset_level", key_level, 2'b00);
    check_vec("reset_press", key_press, 2'b00);
    check_vec("reset_release", key_release, 2'b00);

    // Reset held with keys idle, then a quiet run
    repeat (5) step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      pulses += $countones(key_press) + $countones(key_release);
    end
    check_int("quiet_pulses", pulses, 0);
    check_vec("quiet_level", key_level, 2'b00);

    // Clean press on key0
    key_raw[0] = 1'b0;
    wait_pulse(1'b0, 40, n, seen);
    check_int("press_latency", n, 18);
    check_vec("press_bits", seen, 2'b01);
    repeat (10) step();
    check_vec("press_hold_level", key_level, 2'b01);

    // Release key0
    key_raw[0] = 1'b1;
    wait_pulse(1'b1, 40, n, seen);
    check_int("release_latency", n, 18);
    check_vec("release_bits", seen, 2'b01);
    repeat (10) step();
    check_vec("release_hold_level", key_level, 2'b00);

    // Bounce: toggles every 5 clocks for 60 clocks, then settles low
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      key_raw[0] = ~key_raw[0];
      for (int i = 0; i < 5; i++) begin
        step();
        pulses += $countones(key_press) + $countones(key_release);
      end
    end
    check_int("bounce_pulses", pulses, 0);
    key_raw[0] = 1'b0;
    wait_pulse(1'b0, 40, n, seen);
    check_int("bounce_press_latency", n, 18);
    key_raw[0] = 1'b1;
    repeat (25) step();
    check_vec("bounce_released", key_level, 2'b00);

    // Simultaneous press of both keys
    key_raw = 2'b00;
    wait_pulse(1'b0, 40, n, seen);
    check_int("dual_latency", n, 18);
    check_vec("dual_bits", seen, 2'b11);
    key_raw = 2'b11;
    wait_pulse(1'b1, 40, n, seen);
    check_vec("dual_release_bits", seen, 2'b11);
    repeat (5) step();

    // 15-clock low glitch on key1 only
    pulses = 0;
    key_raw[1] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      pulses += $countones(key_press) + $countones(key_release);
    end
    key_raw[1] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      pulses += $countones(key_press) + $countones(key_release);
    end
    check_int("glitch_pulses", pulses, 0);
    check_vec("glitch_level", key_level, 2'b00);

    // Reset mid-count with key0 held
    key_raw[0] = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check_vec("midrst_level", key_level, 2'b00);
    repeat (3) step();
    rst = 1'b0;
    wait_pulse(1'b0, 40, n, seen);
    check_int("midrst_latency", n, 18);
    check_vec("midrst_bits", seen, 2'b01);
    key_raw[0] = 1'b1;
    repeat (25) step();

    // Random hold lengths around the debounce threshold on both keys
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_raw[k] = 1'($urandom_range(0, 1));
          hold[k]    = int'($urandom_range(1, 30));
        end
        hold[k]--;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
